// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the BCD display path: digit geometry, active-low
// seven-segment codes ({dp,g,f,e,d,c,b,a}), the converter state encoding and
// two small decode helpers used by the top level.
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam int DIGITS = 8;
    localparam int NIBBLE = 4;
    localparam int BCD_W  = DIGITS * NIBBLE;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Nibbles above 9 cannot come out of the converter; they render blank.
    function automatic logic [7:0] seg_encode(input logic [NIBBLE-1:0] nib);
        logic [7:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Index of the most significant nonzero nibble; 0 when the value is 0,
    // so digit 0 is never blanked.
    function automatic logic [2:0] msd_index(input logic [BCD_W-1:0] bcd);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[NIBBLE*i +: NIBBLE] != '0) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 (double-dabble) binary to 8-digit BCD converter.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : load 'bin' (accepted in IDLE, and in COMMIT to chain a reload)
//   bin       : unsigned binary operand
//   busy      : converter not IDLE
//   done      : high for the single COMMIT cycle; 'bcd' is final then
//   bcd       : packed BCD result (upper 32 bits of the shift register)
// ----------------------------------------------------------------------------
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BITWIDTH-1:0] bin,
    output logic                busy,
    output logic                done,
    output logic [BCD_W-1:0]    bcd
);

    localparam int SR_W   = BCD_W + BITWIDTH;
    localparam int ITER_W = $clog2(BITWIDTH + 1);

    conv_state_e         state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [SR_W-1:0]     adj;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        sr_d    = sr_q;
        iter_d  = iter_q;
        adj     = sr_q;

        // Add 3 to each BCD nibble >= 5 before the shift.
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[BITWIDTH + NIBBLE*i +: NIBBLE] >= 4'd5) begin
                adj[BITWIDTH + NIBBLE*i +: NIBBLE] =
                    sr_q[BITWIDTH + NIBBLE*i +: NIBBLE] + 4'd3;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = {{BCD_W{1'b0}}, bin};
                    iter_d  = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                sr_d   = {adj[SR_W-2:0], 1'b0};
                iter_d = iter_q + 1'b1;
                if (iter_q == ITER_W'(BITWIDTH - 1)) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (start) begin
                    sr_d    = {{BCD_W{1'b0}}, bin};
                    iter_d  = '0;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            iter_q  <= iter_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_COMMIT);
    assign bcd  = sr_q[SR_W-1 -: BCD_W];

endmodule

// File: rtl/seg_scan_bcd.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// seg_scan_bcd
// Converts a strobed binary value to BCD and shows it on an 8-digit,
// time-multiplexed, active-low seven-segment display with leading-zero
// blanking.
//   clk, rst   : display clock, asynchronous active-low reset
//   num_valid  : single-cycle strobe sampling 'num'
//   num        : unsigned binary value
//   busy       : conversion in progress
//   bcd_valid  : one-cycle pulse when the displayed value is updated
//   SEG        : {dp,g,f,e,d,c,b,a}, active-low, registered
//   AN         : one-hot active-low anodes, bit 0 = rightmost, registered
// ----------------------------------------------------------------------------
module seg_scan_bcd
    import seg_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                num_valid,
    input  logic [BITWIDTH-1:0] num,
    output logic                busy,
    output logic                bcd_valid,
    output logic [7:0]          SEG,
    output logic [7:0]          AN
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic                conv_busy, conv_done, conv_start;
    logic [BITWIDTH-1:0] conv_bin;
    logic [BCD_W-1:0]    conv_bcd;

    logic                pending_q, pending_d;
    logic [BITWIDTH-1:0] pend_num_q, pend_num_d;
    logic [BCD_W-1:0]    disp_bcd_q, disp_bcd_d;
    logic                bcd_valid_q, bcd_valid_d;
    logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [7:0]          an_q, an_d;

    bin2bcd_seq #(.BITWIDTH(BITWIDTH)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        pending_d   = pending_q;
        pend_num_d  = pend_num_q;
        disp_bcd_d  = disp_bcd_q;
        bcd_valid_d = conv_done;
        scan_cnt_d  = scan_cnt_q + 1'b1;
        idx_d       = idx_q;

        // A strobe in COMMIT is chained straight into the reload (newest
        // value wins over any older pending one), so it is never dropped.
        conv_start = num_valid || (conv_done && pending_q);
        conv_bin   = num_valid ? num : pend_num_q;

        if (conv_done) begin
            pending_d  = 1'b0;
            disp_bcd_d = conv_bcd;
        end else if (conv_busy && num_valid) begin
            pending_d  = 1'b1;
            pend_num_d = num;
        end

        if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end

        // Decode from next-state values so SEG/AN always reflect the digit
        // and display contents that are live in the same cycle.
        if (idx_d > msd_index(disp_bcd_d)) seg_d = SEG_BLANK;
        else                               seg_d = seg_encode(disp_bcd_d[NIBBLE*idx_d +: NIBBLE]);
        an_d = AN_OFF ^ (8'd1 << idx_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q   <= 1'b0;
            pend_num_q  <= '0;
            disp_bcd_q  <= '0;
            bcd_valid_q <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= 3'd0;
            seg_q       <= SEG_0;
            an_q        <= 8'hFE;
        end else begin
            pending_q   <= pending_d;
            pend_num_q  <= pend_num_d;
            disp_bcd_q  <= disp_bcd_d;
            bcd_valid_q <= bcd_valid_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign busy      = conv_busy;
    assign bcd_valid = bcd_valid_q;
    assign SEG       = seg_q;
    assign AN        = an_q;

endmodule

// File: doc/seg_scan_bcd.md
# seg_scan_bcd

Downstream display stage for the linked-list sum datapath: accepts the binary `sum_value` result with a load strobe, converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, and drives an 8-digit multiplexed, active-low seven-segment display with leading-zero blanking. It replaces a fixed single-digit anode pattern with a real time-multiplexed scan. The scan runs from the fast display clock domain; `num`/`num_valid` must be synchronous to that same clock.

## Interface
- `BITWIDTH`, 8, width of binary input; legal range 4..26, so the value fits 8 decimal digits.
- `SCAN_DIV`, 100_000, clk cycles each digit stays lit; legal range ≥1.
- `clk` input 1 — sole clock, rising edge.
- `rst` input 1 — reset, asynchronous, active-low.
- `num_valid` input 1 — single-cycle strobe; `num` is sampled on this cycle.
- `num` input BITWIDTH — unsigned binary value to display.
- `busy` output 1 — conversion in progress.
- `bcd_valid` output 1 — one-cycle pulse when the display register is updated.
- `SEG` output 8 — segments {dp,g,f,e,d,c,b,a}, active-low.
- `AN` output 8 — digit anodes, one-hot active-low; bit 0 is the rightmost digit.

## Operation
- Converter FSM states: IDLE, CONV, COMMIT.
  - IDLE + `num_valid`: load shift register = {32'b0, num}, iteration counter = 0, go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift left 1. After BITWIDTH iterations, go to COMMIT.
  - COMMIT: copy the 8-nibble BCD into `disp_bcd` and pulse `bcd_valid`. If pending is set, reload from `pend_num` and go to CONV; otherwise go to IDLE.
- `num_valid` while not IDLE: capture `num` into `pend_num` and set pending. A later strobe overwrites `pend_num`, so only the newest value is kept. Pending clears when it is consumed.
- `busy` = state ≠ IDLE.
- Scan: counter runs 0..SCAN_DIV-1. On wrap, digit index advances mod 8 (7 → 0).
- Digit decode: nibble = `disp_bcd[4*idx +: 4]`.
  - Blank (SEG = FF) when idx > index of the most significant nonzero nibble. Digit 0 is never blanked.
  - Nibbles >9 are impossible by construction; decode them as blank.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF. dp is always 1 (off).
- `disp_bcd` changes only in COMMIT. The display never shows a partial conversion.

## Timing
- Reset (asynchronous assert; release is sampled on `clk`):
  - state IDLE, pending 0, `disp_bcd` 0, scan counter 0, idx 0.
  - `busy`=0, `bcd_valid`=0, AN=FE, SEG=C0 (shows "0").
- Strobe sampled in cycle t:
  - `busy`=1 in cycles t+1..t+BITWIDTH+1.
  - `disp_bcd` updates and `bcd_valid`=1 in cycle t+BITWIDTH+2.
  - `busy`=0 in that same cycle, unless pending is set.
  - Latency is BITWIDTH+2 cycles.
- With a pending value: `busy` stays high continuously and the next `bcd_valid` follows BITWIDTH+1 cycles later.
- `num_valid` in the same cycle as COMMIT with nothing pending: the value becomes pending and is converted next. It is not lost.
- SEG/AN are registered and change on the same edge. Each digit is lit for exactly SCAN_DIV cycles. A full frame is 8·SCAN_DIV cycles.
- Reset mid-conversion: result and pending are discarded, and the display returns to "0".
- No output glitches at `disp_bcd` update: SEG for the current idx switches cleanly to the new value on the commit edge.

## Structure
- Package `seg_pkg`:
  - DIGITS=8, NIBBLE=4.
  - Segment code constants SEG_0..SEG_9 and SEG_BLANK.
  - AN_OFF=8'hFF.
  - Converter state encoding.
- Sub-module `bin2bcd_seq`:
  - Contains the double-dabble engine plus the IDLE/CONV/COMMIT FSM.
  - Ports: start, bin, busy, done, bcd[31:0].
- The top level holds pending capture, `disp_bcd`, the scan counter/index, blanking logic and the segment decode.

## Test plan
- Reset: hold `rst`=0, then release → AN=FE, SEG=C0, `busy`=0, with no `bcd_valid` pulse.
- BITWIDTH=8, SCAN_DIV=2, strobe num=8'd207:
  - `bcd_valid` exactly 10 cycles later.
  - Scan shows digit0=F8 ("7"), digit1=C0 ("0"), digit2=A4 ("2"), digits 3..7 = FF.
  - AN cycles FE, FD, FB, … 7F, with each step lasting 2 cycles.
- num=0 → only digit0 shows C0; all others FF. num=255 → digits 5,5,2 (92,92,A4).
- Strobes 17, 200 and 99 issued while busy with 17:
  - Exactly two `bcd_valid` pulses, showing 17 then 99.
  - `busy` stays high continuously between them.
- Reset asserted mid-conversion of 123 after 100 was displayed → display returns to "0", `busy`=0, with no `bcd_valid`.
- Exhaustive 0..255 with SCAN_DIV=1 → decode `disp_bcd` after each `bcd_valid`; it must equal the value in decimal, with blanking correct.
